// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// Sits between the adder result and the 7-segment digit decoders.
module bin2bcd_seq #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3,
  parameter int CW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   sr_q;
  logic [SW-1:0]   sr_adj;
  logic [SW-1:0]   sr_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   bcd_q;

  // Digit fields live above the binary part; each >= 5 is corrected before the shift.
  function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic [3:0]    dig;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      dig = v[WIDTH+4*d +: 4];
      if (dig >= 4'd5) begin
        r[WIDTH+4*d +: 4] = dig + 4'd3;
      end
    end
    return r;
  endfunction

  assign sr_adj = add3_digits(sr_q);
  assign sr_d   = {sr_adj[SW-2:0], 1'b0};
  assign cnt_d  = cnt_q - CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q    <= {{BW{1'b0}}, bin};
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_d;
          if (cnt_q == CW'(1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          // bcd only changes here, so intermediate digits never reach the display.
          bcd_q   <= sr_q[SW-1 -: BW];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Takes the 9-bit unsigned adder result (0..511) and produces three BCD digits for the 7-segment display decoders.
- Sits between the adder datapath and the display drivers.
- Performs one shift per clock, under a start/busy/done handshake.

Parameters:
- WIDTH, 9, binary input width. Must satisfy 2^WIDTH-1 < 10^DIGITS.
- DIGITS, 3, number of BCD output digits.
- CW, 4, width of the iteration counter. Must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd has been updated.
- bcd  output  4*DIGITS  result digits. bcd[3:0] is ones, bcd[7:4] is tens, bcd[11:8] is hundreds.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values (taking effect immediately on rst, without waiting for a clock edge):
  - state = IDLE, busy = 0, done = 0, bcd = 0.
  - Shift register = 0, counter = 0.
- State machine: IDLE, SHIFT, FINISH.
- IDLE:
  - busy = 0.
  - When start = 1 at an edge: load the shift register with {DIGITS*4 zeros, bin}, set counter = WIDTH, go to SHIFT.
  - When start = 0: remain in IDLE.
- SHIFT, once per clock:
  - Every 4-bit digit field in the upper part of the shift register that is >= 5 gets +3 added, combinationally in the same cycle.
  - Then the whole register shifts left by 1 and the counter decrements.
  - When the counter reaches 1 on this edge (last shift), go to FINISH.
  - Exactly WIDTH shift edges occur.
- FINISH, a single cycle:
  - Copy the digit field to the bcd register.
  - Assert done for this cycle only, then return to IDLE.
- busy is high in SHIFT and FINISH, and low in IDLE.
- Latency, with start sampled at edge E0:
  - busy rises after E0.
  - Shifts occur at E1..E9.
  - FINISH is the cycle after E9: bcd becomes valid at edge E10, and done is high during the cycle following E10.
  - Total: WIDTH+1 edges from the start edge to bcd updated, for WIDTH = 9.
- Busy handling:
  - start while busy is ignored; no queuing, and bin is not resampled.
  - bcd holds the previous result throughout a conversion. Intermediate values never appear on bcd.
- Back-to-back: start asserted in the cycle done = 1 (state already IDLE) is accepted at the next edge. Sustained throughput is one conversion per WIDTH+2 cycles.
- Arithmetic:
  - Add-3 is applied per digit on 4-bit values before the shift; no digit exceeds 9 after conversion.
  - Input 511 yields 0x511. No overflow is possible for the legal parameter set.
- Reset mid-conversion:
  - Aborts immediately; all outputs return to reset values.
  - bcd is cleared to 0 and no done pulse is issued.
  - The next start after reset release behaves normally.
- start held high continuously: a new conversion begins each time IDLE is re-entered.

Test Plan:
- Reset, then start with bin = 0 -> busy high for 10 cycles, done pulses once, bcd = 0x000.
- bin = 511 -> bcd = 0x511 (hundreds 5, tens 1, ones 1). Done is seen exactly 10 edges after the start edge.
- Sequence bin = 255, 100, 9, 10, 99 -> bcd = 0x255, 0x100, 0x009, 0x010, 0x099. Between conversions, bcd holds the old value while busy.
- bin = 123 started; start pulsed with bin = 400 at cycle 4 of the conversion -> result 0x123 with a single done pulse; 400 is never converted.
- start held high continuously with bin = 37 -> done pulses every 11 cycles, bcd = 0x037 each time.
- bin = 300 started; rst asserted asynchronously mid-cycle at shift 5 -> busy, done and bcd drop to 0 without waiting for a clock edge. After release, bin = 42 converts to 0x042.
